alu_seq_unit: RTL

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_pkg.sv | 83 ++++++++
 rtl/alu_iter_muldiv.sv | 95 +++++++++
 rtl/alu_seq_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Opcode values, ALU control codes and FSM states shared by the sequential ALU.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b01001;
    localparam logic [4:0] OP_MULT = 5'b01010;
    localparam logic [4:0] OP_DIV  = 5'b01011;
    localparam logic [4:0] OP_SL   = 5'b01100;
    localparam logic [4:0] OP_SR   = 5'b01101;
    localparam logic [4:0] OP_AND  = 5'b01110;
    localparam logic [4:0] OP_OR   = 5'b01111;
    localparam logic [4:0] OP_XOR  = 5'b10000;
    localparam logic [4:0] OP_NOR  = 5'b10001;
    localparam logic [4:0] OP_JR   = 5'b10010;
    localparam logic [4:0] OP_NAND = 5'b10011;
    localparam logic [4:0] OP_NOT  = 5'b10100;
    localparam logic [4:0] OP_SLT  = 5'b10101;
    localparam logic [4:0] OP_SGT  = 5'b10110;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b11;

    typedef enum logic [3:0] {
        CTL_ADD     = 4'b0000,
        CTL_SUB     = 4'b0001,
        CTL_MULT    = 4'b0010,
        CTL_DIV     = 4'b0011,
        CTL_SL      = 4'b0100,
        CTL_SR      = 4'b0101,
        CTL_AND     = 4'b0110,
        CTL_OR      = 4'b0111,
        CTL_XOR     = 4'b1000,
        CTL_NOR     = 4'b1001,
        CTL_JR      = 4'b1010,
        CTL_NAND    = 4'b1011,
        CTL_NOT     = 4'b1100,
        CTL_SLT     = 4'b1101,
        CTL_SGT     = 4'b1110,
        CTL_ILLEGAL = 4'b1111
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // aluop 00/11 override the opcode; only 01/10 consult the decode table.
    function automatic alu_ctl_e decode_ctl(input logic [1:0] aluop, input logic [4:0] op);
        alu_ctl_e ctl;
        ctl = CTL_ILLEGAL;
        if (aluop == ALUOP_ADD) begin
            ctl = CTL_ADD;
        end else if (aluop == ALUOP_SUB) begin
            ctl = CTL_SUB;
        end else begin
            case (op)
                OP_ADD:  ctl = CTL_ADD;
                OP_SUB:  ctl = CTL_SUB;
                OP_MULT: ctl = CTL_MULT;
                OP_DIV:  ctl = CTL_DIV;
                OP_SL:   ctl = CTL_SL;
                OP_SR:   ctl = CTL_SR;
                OP_AND:  ctl = CTL_AND;
                OP_OR:   ctl = CTL_OR;
                OP_XOR:  ctl = CTL_XOR;
                OP_NOR:  ctl = CTL_NOR;
                OP_JR:   ctl = CTL_JR;
                OP_NAND: ctl = CTL_NAND;
                OP_NOT:  ctl = CTL_NOT;
                OP_SLT:  ctl = CTL_SLT;
                OP_SGT:  ctl = CTL_SGT;
                default: ctl = CTL_ILLEGAL;
            endcase
        end
        return ctl;
    endfunction

    function automatic logic is_iterative(input alu_ctl_e ctl);
        return (ctl == CTL_MULT) || (ctl == CTL_DIV);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
// for exactly WIDTH cycles. The acc/mq register pair holds {hi, lo} for both ops.
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    import alu_seq_pkg::*;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH-1:0] acc_step, mq_step;
    logic [WIDTH:0]   add_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // With b == 0 every trial subtraction succeeds, so the quotient fills with ones
    // and the remainder ends up holding a without any special casing.
    always_comb begin
        add_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_ge    = div_shift >= {1'b0, opnd_q};
        if (is_div_q) begin
            acc_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
            mq_step  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = add_sum[WIDTH:1];
            mq_step  = {add_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == LAST);
    assign lo   = mq_step;
    assign hi   = acc_step;

    always_comb begin
        acc_d    = acc_q;
        mq_d     = mq_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        is_div_d = is_div_q;
        if (start) begin
            acc_d    = '0;
            mq_d     = a;
            opnd_d   = b;
            is_div_d = is_div;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_step;
            mq_d  = mq_step;
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith ops, iterative mult/div, and a
// valid/ready handshake on both sides with one operation in flight at a time.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [1:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);
    import alu_seq_pkg::*;

    state_e           state_q, state_d;
    alu_ctl_e         ctl;
    logic             accept;
    logic [WIDTH-1:0] alu_res;

    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    assign ctl    = decode_ctl(aluop, op);
    assign accept = in_valid && in_ready;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_iterative(ctl)),
        .is_div (ctl == CTL_DIV),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_comb begin
        alu_res = '0;
        case (ctl)
            CTL_ADD:  alu_res = a + b;
            CTL_SUB:  alu_res = a - b;
            CTL_SL:   alu_res = a << b[SHW-1:0];
            CTL_SR:   alu_res = a >> b[SHW-1:0];
            CTL_AND:  alu_res = a & b;
            CTL_OR:   alu_res = a | b;
            CTL_XOR:  alu_res = a ^ b;
            CTL_NOR:  alu_res = ~(a | b);
            CTL_JR:   alu_res = a;
            CTL_NAND: alu_res = ~(a & b);
            CTL_NOT:  alu_res = ~a;
            CTL_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            CTL_SGT:  alu_res = WIDTH'($signed(a) > $signed(b));
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_iterative(ctl) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Flags are refreshed on every accept; iterative results land when the datapath finishes.
    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        if (accept) begin
            dbz_d = (ctl == CTL_DIV) && (b == '0);
            ill_d = (ctl == CTL_ILLEGAL);
            if (!is_iterative(ctl)) begin
                result_d    = alu_res;
                result_hi_d = '0;
                zero_d      = (alu_res == '0);
            end
        end else if ((state_q == ST_BUSY) && md_done) begin
            result_d    = md_lo;
            result_hi_d = md_hi;
            zero_d      = (md_lo == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
        end
    end

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule
